mem_wb_skid: RTL

- Parametrised MEM/WB pipeline boundary for the RISC-V core; next generation of the plain MEM/WB latch.
- Carries NUM_CH register-write channels from MEM to the register-file write-back port.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput under downstream stall), synchronous flush, and x0-write suppression.

---
 rtl/mem_wb_skid_pkg.sv | 16 +
 rtl/mem_wb_skid_pipe_slot.sv | 53 +++++
 rtl/mem_wb_skid.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_wb_skid_pkg.sv
// mem_wb_skid_pkg: shared definitions for the MEM/WB skid boundary.
//   - state_t       : handshake FSM states (EMPTY / ONE / FULL)
//   - RST_ENABLE    : active level of rst
//   - WRITE_DISABLE : value of a disabled per-channel write enable
package mem_wb_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/mem_wb_skid_pipe_slot.sv
// pipe_slot: one write-back payload register (NUM_CH channels).
//   clk, rst         : clock, async active-high reset (clears payload)
//   clear            : synchronous clear to zero (wins over load)
//   load             : capture in_* this edge
//   in_wd/in_wreg/in_wdata : packed payload to capture
//   wd/wreg/wdata    : registered payload
// A channel whose destination is x0 is captured with its write enable
// forced off; its address and data are kept as presented.
module pipe_slot
  import mem_wb_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CH*ADDR_W-1:0] in_wd,
  input  logic [NUM_CH-1:0]        in_wreg,
  input  logic [NUM_CH*DATA_W-1:0] in_wdata,
  output logic [NUM_CH*ADDR_W-1:0] wd,
  output logic [NUM_CH-1:0]        wreg,
  output logic [NUM_CH*DATA_W-1:0] wdata
);

  logic [NUM_CH-1:0] cap_wreg;

  always_comb begin
    cap_wreg = in_wreg;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (in_wd[i*ADDR_W +: ADDR_W] == '0) cap_wreg[i] = WRITE_DISABLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      wd    <= '0;
      wreg  <= {NUM_CH{WRITE_DISABLE}};
      wdata <= '0;
    end else if (clear) begin
      wd    <= '0;
      wreg  <= {NUM_CH{WRITE_DISABLE}};
      wdata <= '0;
    end else if (load) begin
      wd    <= in_wd;
      wreg  <= cap_wreg;
      wdata <= in_wdata;
    end
  end

endmodule

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM/WB pipeline boundary with valid/ready handshake and a
// 2-entry skid buffer (main slot drives wb_*, skid slot holds overflow).
//   clk, rst    : clock, async active-high reset
//   flush       : synchronous flush, drops every buffered beat
//   mem_valid/mem_ready, mem_wd/mem_wreg/mem_wdata : upstream beat
//   wb_valid/wb_ready,  wb_wd/wb_wreg/wb_wdata     : downstream beat
//   stall_cnt   : cycles with wb_valid & ~wb_ready (saturating)
// Build option: define MEM_WB_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt is tied to zero.
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
  input  logic [NUM_CH-1:0]        mem_wreg,
  input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [NUM_CH*ADDR_W-1:0] wb_wd,
  output logic [NUM_CH-1:0]        wb_wreg,
  output logic [NUM_CH*DATA_W-1:0] wb_wdata,
  output logic [31:0]              stall_cnt
);

  state_t state_q, state_d;

  logic in_fire, out_fire;
  logic main_load, main_clear, skid_load, skid_clear;

  logic [NUM_CH*ADDR_W-1:0] skid_wd,   main_src_wd;
  logic [NUM_CH-1:0]        skid_wreg, main_src_wreg;
  logic [NUM_CH*DATA_W-1:0] skid_wdata, main_src_wdata;

  // Both handshake outputs decode straight from the state flop, so
  // wb_ready never reaches mem_ready combinationally.
  assign wb_valid  = (state_q != EMPTY);
  assign mem_ready = (state_q != FULL);
  assign in_fire   = mem_valid & mem_ready;
  assign out_fire  = wb_valid & wb_ready;

  // In FULL the main slot refills from the skid slot, never from MEM.
  always_comb begin
    if (state_q == FULL) begin
      main_src_wd    = skid_wd;
      main_src_wreg  = skid_wreg;
      main_src_wdata = skid_wdata;
    end else begin
      main_src_wd    = mem_wd;
      main_src_wreg  = mem_wreg;
      main_src_wdata = mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) state_q <= EMPTY;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
      state_d    = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = ONE;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_d    = EMPTY;
        end
      endcase
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) u_main (
    .clk      (clk),
    .rst      (rst),
    .clear    (main_clear),
    .load     (main_load),
    .in_wd    (main_src_wd),
    .in_wreg  (main_src_wreg),
    .in_wdata (main_src_wdata),
    .wd       (wb_wd),
    .wreg     (wb_wreg),
    .wdata    (wb_wdata)
  );

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (skid_clear),
    .load     (skid_load),
    .in_wd    (mem_wd),
    .in_wreg  (mem_wreg),
    .in_wdata (mem_wdata),
    .wd       (skid_wd),
    .wreg     (skid_wreg),
    .wdata    (skid_wdata)
  );

`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stall_q;

  // Only reset clears the counter; flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      stall_q <= '0;
    end else if (wb_valid && !wb_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
